// File: rtl/mc_mem_pkg.sv
// ---------------------------------------------------------------------------
// mc_mem_pkg
// Shared definitions for the multi-cycle memory access unit (mem_if_mc) and
// its lane steering helper (mem_lane_align):
//   - memSize_e   : access size encodings MEM_BYTE / MEM_HALF / MEM_WORD
//   - mifState_e  : access FSM states MIF_IDLE / MIF_REQ / MIF_DONE
//   - XLEN        : data/address width (the lane logic assumes 4 byte lanes)
//   - RST_INSTR   : IR value after reset (NOP: addi x0,x0,0)
//   - normSize()  : folds the spare size code 2'b11 onto a word access
// ---------------------------------------------------------------------------
package mc_mem_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RST_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } memSize_e;

   typedef enum logic [1:0] {
      MIF_IDLE = 2'b00,
      MIF_REQ  = 2'b01,
      MIF_DONE = 2'b10
   } mifState_e;

   // The controller may present 2'b11; it behaves exactly like a word access.
   function automatic memSize_e normSize(input logic [1:0] rawSize);
      memSize_e result;
      case (rawSize)
         2'b00:   result = MEM_BYTE;
         2'b01:   result = MEM_HALF;
         default: result = MEM_WORD;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for a 32-bit, 4-lane bus.
// Store side: replicates the low bits of the store data across all lanes and
// builds the byte enables for the addressed lane(s).
// Load side: pulls the addressed lane out of the read buffer and sign- or
// zero-extends it.
// Ports:
//   size_i       in   access size (memSize_e)
//   off_i        in   2  byte offset of the access within the word
//   ext_i        in   1  load extension: 1 sign, 0 zero
//   storeData_i  in   32 store value, low bits significant
//   rbuf_i       in   32 read buffer holding the last word read
//   wdata_o      out  32 lane-replicated store data
//   be_o         out  4  byte enables
//   loadData_o   out  32 extracted and extended load value
// ---------------------------------------------------------------------------
module mem_lane_align (
   input  mc_mem_pkg::memSize_e size_i,
   input  logic [1:0]           off_i,
   input  logic                 ext_i,
   input  logic [31:0]          storeData_i,
   input  logic [31:0]          rbuf_i,
   output logic [31:0]          wdata_o,
   output logic [3:0]           be_o,
   output logic [31:0]          loadData_o
);
   import mc_mem_pkg::*;

   logic [7:0]  byteLane;
   logic [15:0] halfLane;

   // Store steering: every lane carries a copy of the data so the memory
   // only needs the byte enables to pick the right one. A half access only
   // looks at off[1], so off[0] never splits a halfword across the word.
   always_comb begin
      wdata_o = storeData_i;
      be_o    = 4'b1111;
      case (size_i)
         MEM_BYTE: begin
            wdata_o = {4{storeData_i[7:0]}};
            be_o    = 4'b0001 << off_i;
         end
         MEM_HALF: begin
            wdata_o = {2{storeData_i[15:0]}};
            be_o    = off_i[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata_o = storeData_i;
            be_o    = 4'b1111;
         end
      endcase
   end

   // Load extraction: select the lane named by the offset, then extend from
   // its top bit when sign extension is requested. Words pass straight through.
   always_comb begin
      byteLane   = rbuf_i[{off_i, 3'b000} +: 8];
      halfLane   = off_i[1] ? rbuf_i[31:16] : rbuf_i[15:0];
      loadData_o = rbuf_i;
      case (size_i)
         MEM_BYTE: loadData_o = {{24{ext_i & byteLane[7]}}, byteLane};
         MEM_HALF: loadData_o = {{16{ext_i & halfLane[15]}}, halfLane};
         default:  loadData_o = rbuf_i;
      endcase
   end

endmodule

// File: rtl/mem_if_mc.sv
// ---------------------------------------------------------------------------
// mem_if_mc
// Memory access unit driven by the multi-cycle controller. A start pulse in
// IDLE latches one access (instruction fetch at pc, or data access at
// alu_addr), runs a req/ack bus handshake on a word-aligned address and then
// pulses done. Holds the instruction register (IR) and memory data register
// (MDR), loaded from the read buffer on load_ir / load_mdr.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word data accesses skip the bus and report misalign with done.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start             one-cycle pulse, begins an access (ignored while busy)
//   mem_sel           0 fetch from pc, 1 data access at alu_addr
//   mem_wr_en         store when set (data accesses only)
//   memory_size       00 byte, 01 half, 10/11 word
//   mem_sz_ex_sel     load extension: 1 sign, 0 zero
//   pc, alu_addr      fetch / data address
//   store_data        store value, low bits significant
//   load_ir, load_mdr register load strobes, sampled every cycle
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata   bus request side
//   bus_rdata/bus_ack                          bus response side
//   ir, mdr           instruction and memory data registers
//   busy              access in flight
//   done              one-cycle completion pulse
//   misalign          misaligned access report (trap build only, else 0)
// ---------------------------------------------------------------------------
module mem_if_mc #(
   parameter int              XLEN      = mc_mem_pkg::XLEN,
   parameter logic [XLEN-1:0] RST_INSTR = mc_mem_pkg::RST_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            mem_sel,
   input  logic            mem_wr_en,
   input  logic [1:0]      memory_size,
   input  logic            mem_sz_ex_sel,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] alu_addr,
   input  logic [XLEN-1:0] store_data,
   input  logic            load_ir,
   input  logic            load_mdr,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [3:0]      bus_be,
   output logic [XLEN-1:0] bus_wdata,
   input  logic [XLEN-1:0] bus_rdata,
   input  logic            bus_ack,
   output logic [XLEN-1:0] ir,
   output logic [XLEN-1:0] mdr,
   output logic            busy,
   output logic            done,
   output logic            misalign
);
   import mc_mem_pkg::*;

   mifState_e       state_q, state_d;
   memSize_e        size_q, reqSize;
   logic [1:0]      off_q;
   logic            ext_q, we_q, busReq_q, misalign_q;
   logic            trapNow, startIdle;
   logic [XLEN-1:0] addrSel, busAddr_q, storeData_q, rdataHold_q, rbuf_q, ir_q, mdr_q;
   logic [XLEN-1:0] laneWdata, laneLoad;
   logic [3:0]      laneBe;

   // A fetch is always a full word at offset 0, whatever size the controller
   // happens to be presenting.
   assign addrSel   = mem_sel ? alu_addr : pc;
   assign reqSize   = mem_sel ? normSize(memory_size) : MEM_WORD;
   assign startIdle = start && (state_q == MIF_IDLE);

   // Misalignment is decided from the incoming address so the FSM can bypass
   // the bus in the very cycle it would otherwise raise bus_req.
`ifdef MEM_MISALIGN_TRAP_EN
   assign trapNow = mem_sel &&
                    (((reqSize == MEM_HALF) && addrSel[0]) ||
                     ((reqSize == MEM_WORD) && (addrSel[1:0] != 2'b00)));
`else
   assign trapNow = 1'b0;
`endif

   // State register. Reset drops straight back to IDLE, so an ack arriving
   // after a mid-transaction reset finds nothing to complete.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= MIF_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. start is only honoured in IDLE (no queueing) and
   // bus_ack only in REQ.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MIF_IDLE: begin
            if (start) begin
               state_d = trapNow ? MIF_DONE : MIF_REQ;
            end
         end
         MIF_REQ: begin
            if (bus_ack) begin
               state_d = MIF_DONE;
            end
         end
         MIF_DONE: state_d = MIF_IDLE;
         default:  state_d = MIF_IDLE;
      endcase
   end

   // Datapath registers. Read data is caught in a holding register on ack
   // and only committed to rbuf as the access retires, so a load strobe on
   // the done cycle still sees the previous contents of rbuf.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busReq_q    <= 1'b0;
         busAddr_q   <= '0;
         we_q        <= 1'b0;
         size_q      <= MEM_WORD;
         ext_q       <= 1'b0;
         off_q       <= 2'b00;
         storeData_q <= '0;
         misalign_q  <= 1'b0;
         rdataHold_q <= '0;
         rbuf_q      <= '0;
         ir_q        <= RST_INSTR;
         mdr_q       <= '0;
      end else begin
         busReq_q <= (state_d == MIF_REQ);
         if (startIdle) begin
            busAddr_q   <= {addrSel[XLEN-1:2], 2'b00};
            we_q        <= mem_sel & mem_wr_en;
            size_q      <= reqSize;
            ext_q       <= mem_sel & mem_sz_ex_sel;
            off_q       <= mem_sel ? addrSel[1:0] : 2'b00;
            storeData_q <= store_data;
            misalign_q  <= trapNow;
         end else if (state_q == MIF_DONE) begin
            misalign_q <= 1'b0;
         end
         if ((state_q == MIF_REQ) && bus_ack && !we_q) begin
            rdataHold_q <= bus_rdata;
         end
         if ((state_q == MIF_DONE) && !we_q && !misalign_q) begin
            rbuf_q <= rdataHold_q;
         end
         if (load_ir) begin
            ir_q <= rbuf_q;
         end
         if (load_mdr) begin
            mdr_q <= laneLoad;
         end
      end
   end

   mem_lane_align u_lane (
      .size_i      (size_q),
      .off_i       (off_q),
      .ext_i       (ext_q),
      .storeData_i (storeData_q),
      .rbuf_i      (rbuf_q),
      .wdata_o     (laneWdata),
      .be_o        (laneBe),
      .loadData_o  (laneLoad)
   );

   // Bus strobes and data are qualified by the registered request so they
   // read as zero whenever no transaction is on the bus.
   assign bus_req   = busReq_q;
   assign bus_we    = busReq_q & we_q;
   assign bus_addr  = busAddr_q;
   assign bus_be    = busReq_q ? laneBe : 4'b0000;
   assign bus_wdata = (busReq_q && we_q) ? laneWdata : '0;
   assign ir        = ir_q;
   assign mdr       = mdr_q;
   assign busy      = (state_q != MIF_IDLE);
   assign done      = (state_q == MIF_DONE);
`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign  = misalign_q;
`else
   assign misalign  = 1'b0;
`endif

endmodule
